fp_result_packer: RTL and testbench

Output stage of the floating-point datapath. It sits directly downstream of the combinational adder/subtractor and accepts its unpacked result fields (sign, 8-bit exponent biased at 127, 23-bit mantissa, overflow/underflow/inexact). It rounds and re-biases the result to IEEE-754 half precision when required, then packs the result into a 32-bit word. Packed results and flags are held in a 2-entry output buffer behind a valid/ready handshake, and the block keeps a sticky exception-flag register and a result counter.

---
 rtl/fp_result_packer.sv | 134 +++++++++++++
 tb/tb_fp_result_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_result_packer.sv
// Purpose: rounds/packs adder results into 32-bit words (single, or half in [15:0]) behind a 2-entry output buffer.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 1 result/cycle sustained.
// Backpressure: in_ready low when both entries are full; it depends only on registered state, not on out_ready.
// Ports: clk/rst (sync active-low); in_valid/in_ready + mode_fp, round_mode, res_* fields and flags;
//        out_valid/out_ready/out_data/out_flags {ovf,unf,inx}; flag_clr/flag_acc sticky flags; result_count.
module fp_result_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_fp,
    input  logic [1:0]       round_mode,
    input  logic             res_sign,
    input  logic [7:0]       res_exp,
    input  logic [22:0]      res_mant,
    input  logic             res_ovf,
    input  logic             res_unf,
    input  logic             res_inx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [2:0]       out_flags,
    input  logic             flag_clr,
    output logic [2:0]       flag_acc,
    output logic [CNT_W-1:0] result_count
);

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
    } entry_t;

    entry_t     ent0;         // head of the buffer
    entry_t     ent1;
    entry_t     new_ent;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Half-precision rounding intermediates
    logic [4:0] he;
    logic [9:0] m;
    logic       g;
    logic       s;
    logic       inc;
    logic [4:0] he_r;
    logic [9:0] m_r;

    assign in_ready  = rst && (count != 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_data  = ent0.dat;
    assign out_flags = ent0.flags;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        he  = 5'(res_exp - 8'd112);
        m   = res_mant[22:13];
        g   = res_mant[12];
        s   = |res_mant[11:0];
        inc = 1'b0;
        case (round_mode)
            2'b00:   inc = g && (s || m[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !res_sign && (g || s);
            default: inc = res_sign && (g || s);
        endcase
        // Mantissa carry ripples straight into the exponent; he reaching 31
        // with m=0 is exactly the infinity encoding.
        {he_r, m_r} = {he, m} + 15'(inc);
    end

    always_comb begin
        new_ent = '0;
        if (mode_fp) begin
            new_ent.dat   = {res_sign, res_exp, res_mant};
            new_ent.flags = {res_ovf, res_unf, res_inx};
        end else if (res_exp == 8'd0 && res_mant == 23'd0) begin
            new_ent.dat   = {16'h0, res_sign, 15'h0};
            new_ent.flags = {res_ovf, res_unf, res_inx};
        end else if (res_exp >= 8'd143) begin
            new_ent.dat   = {16'h0, res_sign, 5'h1F, 10'h0};
            new_ent.flags = {1'b1, res_unf, 1'b1};
        end else if (res_exp <= 8'd112) begin
            // Subnormal half results are flushed to signed zero.
            new_ent.dat   = {16'h0, res_sign, 15'h0};
            new_ent.flags = {res_ovf, 1'b1, 1'b1};
        end else begin
            new_ent.dat   = {16'h0, res_sign, he_r, m_r};
            new_ent.flags = {res_ovf || (he_r == 5'h1F), res_unf, res_inx || g || s};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count        <= 2'd0;
            ent0         <= '0;
            ent1         <= '0;
            flag_acc     <= 3'b000;
            result_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= new_ent;
                    else               ent1 <= new_ent;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Push can only coincide with pop when one entry is held.
                    if (count == 2'd1) begin
                        ent0 <= new_ent;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= new_ent;
                    end
                end
                default: ;
            endcase

            if (push)          flag_acc <= (flag_clr ? 3'b000 : flag_acc) | new_ent.flags;
            else if (flag_clr) flag_acc <= 3'b000;

            if (pop) result_count <= result_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_result_packer.sv
module tb_fp_result_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode_fp;
    logic [1:0]  round_mode;
    logic        res_sign;
    logic [7:0]  res_exp;
    logic [22:0] res_mant;
    logic        res_ovf;
    logic        res_unf;
    logic        res_inx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic        flag_clr;
    logic [2:0]  flag_acc;
    logic [15:0] result_count;

    int n_checks = 0;
    int n_fail   = 0;

    fp_result_packer #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_fp(mode_fp), .round_mode(round_mode),
        .res_sign(res_sign), .res_exp(res_exp), .res_mant(res_mant),
        .res_ovf(res_ovf), .res_unf(res_unf), .res_inx(res_inx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags),
        .flag_clr(flag_clr), .flag_acc(flag_acc),
        .result_count(result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic mf, input logic [1:0] rm, input logic sg,
                          input logic [7:0] ex, input logic [22:0] mt, input logic [2:0] fl);
        mode_fp = mf; round_mode = rm; res_sign = sg; res_exp = ex; res_mant = mt;
        {res_ovf, res_unf, res_inx} = fl;
    endtask

    // Called at a negedge; presents one result for a single cycle.
    task automatic send(input logic mf, input logic [1:0] rm, input logic sg,
                        input logic [7:0] ex, input logic [22:0] mt, input logic [2:0] fl);
        set_in(mf, rm, sg, ex, mt, fl);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at a negedge; checks the head entry and then pops it.
    task automatic pop_chk(input string tag, input logic [31:0] d, input logic [2:0] f);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_dat"}, out_data, d);
        chk({tag, "_flg"}, {29'd0, out_flags}, {29'd0, f});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        set_in(1'b0, 2'b00, 1'b0, 8'd0, 23'd0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
        chk("rst_flag_acc", {29'd0, flag_acc}, 32'd0);
        chk("rst_count", {16'd0, result_count}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Single precision passthrough, visible the cycle after accept
        send(1'b1, 2'b00, 1'b1, 8'h80, 23'h400000, 3'b000);
        pop_chk("sp", 32'hC0400000, 3'b000);

        // Half rounding of 1 + 2^-11 under each mode
        send(1'b0, 2'b00, 1'b0, 8'd127, 23'h001000, 3'b000);
        pop_chk("hp_rne", 32'h00003C00, 3'b001);
        send(1'b0, 2'b01, 1'b0, 8'd127, 23'h001000, 3'b000);
        pop_chk("hp_rtz", 32'h00003C00, 3'b001);
        send(1'b0, 2'b10, 1'b0, 8'd127, 23'h001000, 3'b000);
        pop_chk("hp_up", 32'h00003C01, 3'b001);
        send(1'b0, 2'b11, 1'b0, 8'd127, 23'h001000, 3'b000);
        pop_chk("hp_dn", 32'h00003C00, 3'b001);

        // Mantissa carry into exponent, and carry into infinity
        send(1'b0, 2'b00, 1'b0, 8'd127, 23'h7FF000, 3'b000);
        pop_chk("hp_carry", 32'h00004000, 3'b001);
        send(1'b0, 2'b00, 1'b0, 8'd142, 23'h7FF000, 3'b000);
        pop_chk("hp_carry_inf", 32'h00007C00, 3'b101);

        // Range limits
        send(1'b0, 2'b00, 1'b0, 8'd143, 23'h0, 3'b000);
        pop_chk("hp_ovf", 32'h00007C00, 3'b101);
        send(1'b0, 2'b00, 1'b1, 8'd100, 23'h0, 3'b000);
        pop_chk("hp_unf", 32'h00008000, 3'b011);
        send(1'b0, 2'b00, 1'b0, 8'd112, 23'h0, 3'b000);
        pop_chk("hp_unf_edge", 32'h00000000, 3'b011);
        send(1'b0, 2'b00, 1'b0, 8'd113, 23'h0, 3'b000);
        pop_chk("hp_min_norm", 32'h00000400, 3'b000);
        send(1'b0, 2'b00, 1'b1, 8'd0, 23'h0, 3'b000);
        pop_chk("hp_zero", 32'h00008000, 3'b000);
        chk("count_12", {16'd0, result_count}, 32'd12);
        chk("acc_all", {29'd0, flag_acc}, 32'd7);

        // Flag accumulator: clear, overflow, then clear with inexact accept
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("acc_clr0", {29'd0, flag_acc}, 32'd0);
        send(1'b0, 2'b00, 1'b0, 8'd143, 23'h0, 3'b000);
        chk("acc_ovf", {29'd0, flag_acc}, 32'd5);
        pop_chk("acc_ovf_pop", 32'h00007C00, 3'b101);
        flag_clr = 1'b1;
        send(1'b0, 2'b00, 1'b0, 8'd127, 23'h001000, 3'b000);
        flag_clr = 1'b0;
        chk("acc_clr_inx", {29'd0, flag_acc}, 32'd1);
        pop_chk("acc_inx_pop", 32'h00003C00, 3'b001);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("acc_clr1", {29'd0, flag_acc}, 32'd0);
        chk("count_14", {16'd0, result_count}, 32'd14);

        // Mid-stream reset drops the buffered entry, no handshake counted
        send(1'b1, 2'b00, 1'b0, 8'h7F, 23'h0, 3'b000);
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, result_count}, 32'd0);
        chk("mid_rst_dat", out_data, 32'd0);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);

        // Backpressure: two accepted, third held off until a pop
        send(1'b1, 2'b00, 1'b0, 8'h7F, 23'h0, 3'b000);
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        send(1'b1, 2'b00, 1'b0, 8'h80, 23'h0, 3'b000);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        set_in(1'b1, 2'b00, 1'b1, 8'h80, 23'h0, 3'b000);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_dat", out_data, 32'h3F800000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", out_data, 32'h40000000);
        chk("bp_rdy_after_pop", {31'd0, in_ready}, 32'd1);
        chk("bp_count1", {16'd0, result_count}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_head_c", out_data, 32'hC0000000);
        chk("bp_vld_c", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_count3", {16'd0, result_count}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
